prog_mux_bank: RTL and testbench
================================

Name: prog_mux_bank

Overview:
- Bank of CHAN programmable routing muxes. All muxes share one 2**SEL-bit input bus.
- Configuration is loaded serially through a daisy-chained shadow shift register. The shadow is copied atomically into an active register on a validated commit.
- Each channel has a per-channel invert and enable mode. A bit counter rejects commits of short or overlong frames.
- Sits in the CLB routing fabric. prog_out feeds prog_in of the next block in the configuration chain.

Parameters:
- SEL, 4: select bits per channel; each mux has 2**SEL inputs.
- CHAN, 4: number of independent mux channels.
- Derived CFG_W = SEL+2: config bits per channel.
- Derived L = CHAN*CFG_W: frame length in bits.

Ports:
- prog_clk  input  1  configuration clock; the only clock.
- prog_rst_n  input  1  asynchronous active-low reset.
- in  input  2**SEL  shared mux data inputs.
- prog_in  input  1  serial configuration data in.
- prog_en  input  1  shift enable.
- prog_commit  input  1  single-cycle request to transfer shadow to active.
- out  output  CHAN  combinational mux outputs, one bit per channel.
- prog_out  output  1  serial chain out, equal to shadow[L-1].
- cfg_valid  output  1  high once an accepted commit has occurred.
- cfg_err  output  1  sticky error flag for the last rejected commit.

Behaviour:
- Reset (prog_rst_n=0, asynchronous): all of the following clear immediately, including mid-frame:
  - shadow=0, active=0, count=0, state=EMPTY.
  - cfg_valid=0, cfg_err=0, prog_out=0, out=0.
- Shadow shift, on posedge prog_clk with prog_en=1:
  - shadow <= {shadow[L-2:0], prog_in}.
  - prog_out is registered and equals shadow[L-1], so it lags L cycles through the block.
- Frame layout:
  - Channel c occupies shadow[c*CFG_W +: CFG_W].
  - Within a channel: bits [SEL-1:0]=select, bit SEL=invert, bit SEL+1=enable.
  - The first bit shifted in lands in channel CHAN-1's enable bit after L shifts.
- Counter: count is incremented on each shift and saturates at L+1. Width is clog2(L+2).
- FSM, driven by count:
  - EMPTY (count=0) -> LOAD on shift.
  - LOAD (0<count<L) -> FULL when count reaches L.
  - FULL (count=L) -> OVER on a further shift.
  - OVER (count>L) holds until commit or reset.
- Commit, on posedge with prog_commit=1 and prog_en=0:
  - In FULL: active<=shadow, cfg_valid<=1, cfg_err<=0, count<=0, state<=EMPTY.
  - In EMPTY, LOAD or OVER: active unchanged, cfg_valid unchanged, cfg_err<=1, count<=0, state<=EMPTY. The shadow contents are kept.
- Simultaneous prog_commit=1 and prog_en=1:
  - The commit is rejected and cfg_err<=1.
  - The shift still occurs and count increments normally; count is not cleared.
- Data path, combinational from active:
  - out[c] = en_c ? (in[sel_c] ^ inv_c) : 0.
  - Shifting never disturbs out; out changes only on an accepted commit or reset.
- Latency: the new mapping is visible on out in the cycle after the commit edge. in->out has zero cycles of latency.
- cfg_err stays set until the next accepted commit or reset. cfg_valid stays set once set, until reset.

Test Plan (SEL=2, CHAN=2, CFG_W=4, L=8):
1. Reset release, no programming, in=4'b1111:
   - out=2'b00, cfg_valid=0, cfg_err=0, prog_out=0.
2. Shift 8 bits MSB-first 1,1,0,1,1,0,1,0, then pulse commit. This gives shadow 8'hDA: ch0 sel=2, en=1; ch1 sel=1, inv=1, en=1.
   - in=4'b0100 -> out=2'b11.
   - in=4'b0010 -> out=2'b00.
   - cfg_valid=1, cfg_err=0.
3. After test 2, shift 7 bits of 0, then commit:
   - cfg_err=1 and out unchanged, so in=4'b0100 -> out=2'b11.
   - Shift 1 more bit of 0: count=1, so a following commit is also rejected.
4. Shift 9 bits, then commit -> rejected and cfg_err=1. Then shift 8 bits of 0 and commit -> accepted: cfg_err=0, out=2'b00.
5. Chain pass-through: shift 16 bits pattern 8'hDA then 8'h00.
   - prog_out emits 1,1,0,1,1,0,1,0 on shifts 9-16.
   - out is unchanged throughout.
6. Mid-frame reset: assert prog_rst_n=0 after 5 shifts, with an asynchronous pulse not aligned to prog_clk.
   - Outputs clear immediately.
   - A subsequent full 8-bit frame plus commit is accepted.
   - Also: asserting prog_commit together with prog_en on the 8th shift -> cfg_err=1, count=8; a following commit alone is then accepted.

Source files
------------

// File: rtl/prog_mux_bank.sv
// prog_mux_bank
// Bank of CHAN programmable routing muxes sharing one 2**SEL-bit input bus.
// Configuration arrives serially through a daisy-chained shadow register. A
// validated commit copies the shadow atomically into the active register that
// drives the muxes.
//
// Ports:
//   prog_clk    configuration clock (the only clock)
//   prog_rst_n  asynchronous active-low reset
//   in          shared mux data inputs, 2**SEL bits
//   prog_in     serial configuration data in
//   prog_en     shift enable
//   prog_commit single-cycle request to transfer shadow to active
//   out         combinational mux outputs, one bit per channel
//   prog_out    serial chain out (shadow MSB), feeds prog_in of the next block
//   cfg_valid   set by the first accepted commit, held until reset
//   cfg_err     set by a rejected commit, cleared by an accepted commit
//   fsm_state   frame FSM state for debug: 0=EMPTY 1=LOAD 2=FULL 3=OVER
//   bit_count   shift counter for debug, saturates at L+1
//
// Handshake: prog_commit is a single-cycle strobe sampled on the rising edge
// of prog_clk. It is honoured only when prog_en is low in the same cycle and
// exactly L bits have been shifted since the last commit or reset. Any other
// commit strobe is refused and flagged on cfg_err.
//
// Frame layout: channel c occupies shadow[c*CFG_W +: CFG_W], with the select in
// bits [SEL-1:0], the invert flag in bit SEL and the enable flag in bit SEL+1.
module prog_mux_bank #(
  parameter int SEL  = 4,
  parameter int CHAN = 4
) (
  input  logic                                    prog_clk,
  input  logic                                    prog_rst_n,
  input  logic [2**SEL-1:0]                       in,
  input  logic                                    prog_in,
  input  logic                                    prog_en,
  input  logic                                    prog_commit,
  output logic [CHAN-1:0]                         out,
  output logic                                    prog_out,
  output logic                                    cfg_valid,
  output logic                                    cfg_err,
  output logic [1:0]                              fsm_state,
  output logic [$clog2(CHAN*(SEL+2)+2)-1:0]       bit_count
);

  localparam int CFG_W = SEL + 2;
  localparam int L     = CHAN * CFG_W;
  localparam int CW    = $clog2(L + 2);

  localparam logic [CW-1:0] CNT_FULL = CW'(L);
  localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_FULL  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t          state;
  state_t          shift_state;
  logic [L-1:0]    shadow;
  logic [L-1:0]    active;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_inc;

  // Counter value and resulting state if the current cycle shifts. The state
  // is a pure function of the count so the two can never disagree.
  always_comb begin
    count_inc = (count == CNT_SAT) ? count : count + CW'(1);
    if (count_inc == CW'(0)) begin
      shift_state = S_EMPTY;
    end else if (count_inc < CNT_FULL) begin
      shift_state = S_LOAD;
    end else if (count_inc == CNT_FULL) begin
      shift_state = S_FULL;
    end else begin
      shift_state = S_OVER;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shadow    <= '0;
      active    <= '0;
      count     <= '0;
      state     <= S_EMPTY;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (prog_en) begin
      // A commit colliding with a shift is refused; the shift still happens
      // and the frame count keeps running.
      shadow <= {shadow[L-2:0], prog_in};
      count  <= count_inc;
      state  <= shift_state;
      if (prog_commit) begin
        cfg_err <= 1'b1;
      end
    end else if (prog_commit) begin
      if (state == S_FULL) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
      end else begin
        // Short or overlong frame: keep both shadow and active untouched.
        cfg_err <= 1'b1;
      end
      count <= '0;
      state <= S_EMPTY;
    end
  end

  // Shadow is itself a register, so its MSB is the registered chain output.
  assign prog_out  = shadow[L-1];
  assign fsm_state = state;
  assign bit_count = count;

  // Mux datapath driven only by the active register, so shifting never
  // disturbs out.
  always_comb begin
    logic [CFG_W-1:0] cfg;
    cfg = '0;
    out = '0;
    for (int c = 0; c < CHAN; c++) begin
      cfg = active[c*CFG_W +: CFG_W];
      if (cfg[SEL+1]) begin
        out[c] = in[cfg[SEL-1:0]] ^ cfg[SEL];
      end
    end
  end

endmodule

// File: tb/tb_prog_mux_bank.sv
module tb_prog_mux_bank;

  localparam int SEL   = 2;
  localparam int CHAN  = 2;
  localparam int CFG_W = SEL + 2;
  localparam int L     = CHAN * CFG_W;
  localparam int NIN   = 2**SEL;
  localparam int CW    = $clog2(L + 2);

  // ---------------- clock / reset ----------------
  logic prog_clk = 1'b0;
  logic prog_rst_n = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic [NIN-1:0]  in = '0;
  logic            prog_in = 1'b0;
  logic            prog_en = 1'b0;
  logic            prog_commit = 1'b0;
  logic [CHAN-1:0] out;
  logic            prog_out;
  logic            cfg_valid;
  logic            cfg_err;
  logic [1:0]      fsm_state;
  logic [CW-1:0]   bit_count;

  prog_mux_bank #(.SEL(SEL), .CHAN(CHAN)) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .in         (in),
    .prog_in    (prog_in),
    .prog_en    (prog_en),
    .prog_commit(prog_commit),
    .out        (out),
    .prog_out   (prog_out),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err),
    .fsm_state  (fsm_state),
    .bit_count  (bit_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Shadow kept as the history of the last L shifted bits (oldest first);
  // the active mapping is kept already decoded per channel.
  bit m_hist[$];
  int m_count;
  bit m_valid;
  bit m_err;
  int m_sel[CHAN];
  bit m_inv[CHAN];
  bit m_en[CHAN];

  function automatic bit m_shadow_bit(int i);
    return m_hist[L-1-i];
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < L; i++) m_hist.push_back(1'b0);
    m_count = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    for (int c = 0; c < CHAN; c++) begin
      m_sel[c] = 0;
      m_inv[c] = 1'b0;
      m_en[c]  = 1'b0;
    end
  endtask

  task automatic model_edge(input bit en, input bit commit, input bit din);
    if (en) begin
      m_hist.push_back(din);
      void'(m_hist.pop_front());
      if (m_count < L + 1) m_count++;
      if (commit) m_err = 1'b1;
    end else if (commit) begin
      if (m_count == L) begin
        for (int c = 0; c < CHAN; c++) begin
          m_sel[c] = 0;
          for (int k = 0; k < SEL; k++)
            if (m_shadow_bit(c*CFG_W + k)) m_sel[c] += (1 << k);
          m_inv[c] = m_shadow_bit(c*CFG_W + SEL);
          m_en[c]  = m_shadow_bit(c*CFG_W + SEL + 1);
        end
        m_valid = 1'b1;
        m_err   = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_count = 0;
    end
  endtask

  function automatic logic [CHAN-1:0] model_out(logic [NIN-1:0] din);
    logic [CHAN-1:0] r;
    r = '0;
    for (int c = 0; c < CHAN; c++)
      r[c] = m_en[c] ? (din[m_sel[c]] ^ m_inv[c]) : 1'b0;
    return r;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_count == 0) return 2'd0;
    if (m_count < L)  return 2'd1;
    if (m_count == L) return 2'd2;
    return 2'd3;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a quiet point between edges; drives one edge and updates model.
  task automatic clk_cycle(input bit en, input bit commit, input bit din);
    prog_en     = en;
    prog_commit = commit;
    prog_in     = din;
    @(posedge prog_clk);
    #1;
    model_edge(en, commit, din);
    prog_en     = 1'b0;
    prog_commit = 1'b0;
    prog_in     = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) clk_cycle(1'b1, 1'b0, v[i]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    prog_rst_n = 1'b0;
    in = 4'b1111;
    model_reset();
    repeat (2) @(posedge prog_clk);
    #2;
    prog_rst_n = 1'b1;
    #1;
    n_checks++; if (out !== 2'b00) begin n_errors++; $display("FAIL reset_out got=%b exp=%b", out, 2'b00); end
    n_checks++; if (cfg_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", cfg_valid); end
    n_checks++; if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    n_checks++; if (prog_out !== 1'b0) begin n_errors++; $display("FAIL reset_prog_out got=%b exp=0", prog_out); end
    n_checks++; if (bit_count !== CW'(0)) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", bit_count); end
  endtask

  task automatic test_program();
    shift_byte(8'hDA);
    n_checks++; if (fsm_state !== 2'd2) begin n_errors++; $display("FAIL prog_full_state got=%0d exp=2", fsm_state); end
    clk_cycle(1'b0, 1'b1, 1'b0);
    in = 4'b0100; #1;
    n_checks++; if (out !== 2'b11) begin n_errors++; $display("FAIL prog_out_0100 got=%b exp=%b", out, 2'b11); end
    in = 4'b0010; #1;
    n_checks++; if (out !== 2'b00) begin n_errors++; $display("FAIL prog_out_0010 got=%b exp=%b", out, 2'b00); end
    n_checks++; if (cfg_valid !== 1'b1) begin n_errors++; $display("FAIL prog_valid got=%b exp=1", cfg_valid); end
    n_checks++; if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL prog_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 7; i++) clk_cycle(1'b1, 1'b0, 1'b0);
    clk_cycle(1'b0, 1'b1, 1'b0);
    in = 4'b0100; #1;
    n_checks++; if (cfg_err !== 1'b1) begin n_errors++; $display("FAIL short_err got=%b exp=1", cfg_err); end
    n_checks++; if (out !== 2'b11) begin n_errors++; $display("FAIL short_out got=%b exp=%b", out, 2'b11); end
    n_checks++; if (cfg_valid !== 1'b1) begin n_errors++; $display("FAIL short_valid got=%b exp=1", cfg_valid); end
    clk_cycle(1'b1, 1'b0, 1'b0);
    n_checks++; if (bit_count !== CW'(1)) begin n_errors++; $display("FAIL short_count1 got=%0d exp=1", bit_count); end
    clk_cycle(1'b0, 1'b1, 1'b0);
    n_checks++; if (cfg_err !== 1'b1) begin n_errors++; $display("FAIL short_err2 got=%b exp=1", cfg_err); end
    n_checks++; if (out !== 2'b11) begin n_errors++; $display("FAIL short_out2 got=%b exp=%b", out, 2'b11); end
  endtask

  task automatic test_long_frame();
    for (int i = 0; i < 9; i++) clk_cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    n_checks++; if (bit_count !== CW'(L+1)) begin n_errors++; $display("FAIL long_count got=%0d exp=%0d", bit_count, L+1); end
    n_checks++; if (fsm_state !== 2'd3) begin n_errors++; $display("FAIL long_state got=%0d exp=3", fsm_state); end
    clk_cycle(1'b1, 1'b0, 1'b1);
    n_checks++; if (bit_count !== CW'(L+1)) begin n_errors++; $display("FAIL long_sat got=%0d exp=%0d", bit_count, L+1); end
    clk_cycle(1'b0, 1'b1, 1'b0);
    n_checks++; if (cfg_err !== 1'b1) begin n_errors++; $display("FAIL long_err got=%b exp=1", cfg_err); end
    shift_byte(8'h00);
    clk_cycle(1'b0, 1'b1, 1'b0);
    in = 4'b1111; #1;
    n_checks++; if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL long_recover_err got=%b exp=0", cfg_err); end
    n_checks++; if (out !== 2'b00) begin n_errors++; $display("FAIL long_recover_out got=%b exp=%b", out, 2'b00); end
  endtask

  task automatic test_chain();
    logic [7:0] da;
    logic [15:0] stream;
    da = 8'hDA;
    stream = {8'hDA, 8'h00};
    shift_byte(da);
    clk_cycle(1'b0, 1'b1, 1'b0);
    in = 4'b0100; #1;
    for (int k = 1; k <= 16; k++) begin
      // Value presented to the downstream block at shift k.
      if (k >= 9) begin
        n_checks++;
        if (prog_out !== da[16-k]) begin
          n_errors++; $display("FAIL chain_prog_out shift=%0d got=%b exp=%b", k, prog_out, da[16-k]);
        end
      end
      clk_cycle(1'b1, 1'b0, stream[16-k]);
      n_checks++; if (out !== 2'b11) begin n_errors++; $display("FAIL chain_out shift=%0d got=%b exp=%b", k, out, 2'b11); end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] frame;
    clk_cycle(1'b0, 1'b1, 1'b0);  // lone commit at count 0 sets cfg_err
    for (int i = 0; i < 5; i++) clk_cycle(1'b1, 1'b0, 1'b1);
    in = 4'b0100;
    #3;
    prog_rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (out !== 2'b00) begin n_errors++; $display("FAIL midrst_out got=%b exp=%b", out, 2'b00); end
    n_checks++; if (cfg_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid got=%b exp=0", cfg_valid); end
    n_checks++; if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL midrst_err got=%b exp=0", cfg_err); end
    n_checks++; if (bit_count !== CW'(0)) begin n_errors++; $display("FAIL midrst_count got=%0d exp=0", bit_count); end
    n_checks++; if (prog_out !== 1'b0) begin n_errors++; $display("FAIL midrst_prog_out got=%b exp=0", prog_out); end
    @(negedge prog_clk);
    #1;
    prog_rst_n = 1'b1;
    frame = 8'($urandom_range(0, 255));
    frame[3] = 1'b1;
    frame[7] = 1'b1;
    shift_byte(frame);
    clk_cycle(1'b0, 1'b1, 1'b0);
    n_checks++; if (cfg_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_accept got=%b exp=1", cfg_valid); end
    for (int v = 0; v < NIN; v++) begin
      in = NIN'(v); #1;
      n_checks++; if (out !== model_out(in)) begin n_errors++; $display("FAIL midrst_map in=%b got=%b exp=%b", in, out, model_out(in)); end
    end
    // Commit colliding with the 8th shift.
    for (int i = 0; i < 7; i++) clk_cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    clk_cycle(1'b1, 1'b1, 1'b1);
    n_checks++; if (cfg_err !== 1'b1) begin n_errors++; $display("FAIL collide_err got=%b exp=1", cfg_err); end
    n_checks++; if (bit_count !== CW'(L)) begin n_errors++; $display("FAIL collide_count got=%0d exp=%0d", bit_count, L); end
    clk_cycle(1'b0, 1'b1, 1'b0);
    n_checks++; if (cfg_err !== 1'b0) begin n_errors++; $display("FAIL collide_accept_err got=%b exp=0", cfg_err); end
    for (int v = 0; v < NIN; v++) begin
      in = NIN'(v); #1;
      n_checks++; if (out !== model_out(in)) begin n_errors++; $display("FAIL collide_map in=%b got=%b exp=%b", in, out, model_out(in)); end
    end
  endtask

  task automatic test_random();
    int len;
    int pick;
    bit collide;
    for (int b = 0; b < 40; b++) begin
      pick = int'($urandom_range(0, 4));
      case (pick)
        0: len = L - 1;
        1, 2: len = L;
        3: len = L + 1;
        default: len = int'($urandom_range(0, 12));
      endcase
      for (int i = 0; i < len; i++) begin
        collide = ($urandom_range(0, 19) == 0);
        clk_cycle(1'b1, collide, 1'($urandom_range(0, 1)));
        in = NIN'($urandom_range(0, NIN-1)); #1;
        n_checks++; if (out !== model_out(in)) begin n_errors++; $display("FAIL rnd_out in=%b got=%b exp=%b", in, out, model_out(in)); end
        n_checks++; if (prog_out !== m_hist[0]) begin n_errors++; $display("FAIL rnd_prog_out got=%b exp=%b", prog_out, m_hist[0]); end
        n_checks++; if (bit_count !== CW'(m_count)) begin n_errors++; $display("FAIL rnd_count got=%0d exp=%0d", bit_count, m_count); end
        n_checks++; if (cfg_err !== m_err) begin n_errors++; $display("FAIL rnd_err got=%b exp=%b", cfg_err, m_err); end
      end
      if ($urandom_range(0, 3) != 0) clk_cycle(1'b0, 1'b1, 1'b0);
      else clk_cycle(1'b0, 1'b0, 1'b0);
      in = NIN'($urandom_range(0, NIN-1)); #1;
      n_checks++; if (out !== model_out(in)) begin n_errors++; $display("FAIL rnd_commit_out in=%b got=%b exp=%b", in, out, model_out(in)); end
      n_checks++; if (cfg_valid !== m_valid) begin n_errors++; $display("FAIL rnd_valid got=%b exp=%b", cfg_valid, m_valid); end
      n_checks++; if (cfg_err !== m_err) begin n_errors++; $display("FAIL rnd_commit_err got=%b exp=%b", cfg_err, m_err); end
      n_checks++; if (fsm_state !== model_state()) begin n_errors++; $display("FAIL rnd_state got=%0d exp=%0d", fsm_state, model_state()); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_program();
    test_short_frame();
    test_long_frame();
    test_chain();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
